// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronizes and filters the PS/2 lines, frames
// 11-bit packets and turns make/break scancodes into a held-key state.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   ps2_clk    asynchronous PS/2 clock line
//   ps2_data   asynchronous PS/2 data line
//   key_code   scancode of the held key, 8'h00 when none is held
//   key_ready  one-cycle pulse on every accepted make code
//   key_held   high from a make code until its matching break code
//   key_ext    held key's make code was preceded by 8'hE0
//   frame_err  one-cycle pulse on each discarded frame
module ps2_key_decoder #(
   parameter int FILTER_LEN = 8,
   parameter int TIMEOUT    = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] key_code,
   output logic       key_ready,
   output logic       key_held,
   output logic       key_ext,
   output logic       frame_err
);

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   state_t        state;
   state_t        state_nx;

   logic          clk_s1;
   logic          clk_s2;
   logic          dat_s1;
   logic          dat_s2;
   logic [FW-1:0] filt_cnt;
   logic          filt_clk;
   logic          filt_prev;
   logic          fall;

   logic [2:0]    bit_cnt;
   logic [7:0]    shift;
   logic          par_bit;
   logic [TW-1:0] to_cnt;
   logic          timeout;

   logic          start;
   logic          shift_en;
   logic          par_en;
   logic          done;
   logic          good;
   logic          accept;
   logic          reject;

   logic          brk;
   logic          ext;

   // two-flop synchronizers, idle-high
   always_ff @(posedge clk) begin
      if (rst) begin
         clk_s1 <= 1'b1;
         clk_s2 <= 1'b1;
         dat_s1 <= 1'b1;
         dat_s2 <= 1'b1;
      end else begin
         clk_s1 <= ps2_clk;
         clk_s2 <= clk_s1;
         dat_s1 <= ps2_data;
         dat_s2 <= dat_s1;
      end
   end

   // filtered level follows only after FILTER_LEN samples that all
   // differ from it; any sample matching the current level restarts
   always_ff @(posedge clk) begin
      if (rst) begin
         filt_cnt  <= '0;
         filt_clk  <= 1'b1;
         filt_prev <= 1'b1;
      end else begin
         filt_prev <= filt_clk;
         if (clk_s2 == filt_clk) begin
            filt_cnt <= '0;
         end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
            filt_cnt <= '0;
            filt_clk <= clk_s2;
         end else begin
            filt_cnt <= filt_cnt + 1'b1;
         end
      end
   end

   assign fall = filt_prev & ~filt_clk;

   assign timeout = (state != IDLE) && (to_cnt == TW'(TIMEOUT));

   // FSM: state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // FSM: next state
   always_comb begin
      state_nx = state;
      if (timeout) begin
         state_nx = IDLE;
      end else if (fall) begin
         case (state)
            IDLE:    if (!dat_s2) state_nx = DATA;
            DATA:    if (bit_cnt == 3'd7) state_nx = PARITY;
            PARITY:  state_nx = STOP;
            STOP:    state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   // FSM: outputs
   always_comb begin
      start    = 1'b0;
      shift_en = 1'b0;
      par_en   = 1'b0;
      done     = 1'b0;
      if (fall && !timeout) begin
         case (state)
            IDLE:    start    = ~dat_s2;
            DATA:    shift_en = 1'b1;
            PARITY:  par_en   = 1'b1;
            STOP:    done     = 1'b1;
            default: ;
         endcase
      end
   end

   // stop bit high and odd parity over data + parity
   assign good   = dat_s2 & (^{shift, par_bit});
   assign accept = done & good;
   assign reject = done & ~good;

   always_ff @(posedge clk) begin
      if (rst) begin
         bit_cnt <= '0;
         shift   <= '0;
         par_bit <= 1'b0;
         to_cnt  <= '0;
      end else begin
         if (state == IDLE || fall) to_cnt <= '0;
         else if (!timeout)         to_cnt <= to_cnt + 1'b1;

         if (start || timeout) bit_cnt <= '0;
         else if (shift_en)    bit_cnt <= bit_cnt + 1'b1;

         if (shift_en) shift   <= {dat_s2, shift[7:1]};
         if (par_en)   par_bit <= dat_s2;
      end
   end

   // scancode interpretation, one cycle after the stop-bit edge
   always_ff @(posedge clk) begin
      if (rst) begin
         brk       <= 1'b0;
         ext       <= 1'b0;
         key_code  <= 8'h00;
         key_held  <= 1'b0;
         key_ext   <= 1'b0;
         key_ready <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         key_ready <= 1'b0;
         frame_err <= 1'b0;
         if (timeout || reject) begin
            frame_err <= 1'b1;
            brk       <= 1'b0;
            ext       <= 1'b0;
         end else if (accept) begin
            if (shift == 8'hF0) begin
               brk <= 1'b1;
            end else if (shift == 8'hE0) begin
               ext <= 1'b1;
            end else begin
               brk <= 1'b0;
               ext <= 1'b0;
               if (!brk) begin
                  key_code  <= shift;
                  key_ext   <= ext;
                  key_held  <= 1'b1;
                  key_ready <= 1'b1;
               end else if (shift == key_code) begin
                  key_code <= 8'h00;
                  key_held <= 1'b0;
                  key_ext  <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL provide parameter FILTER_LEN, default 8, the number of consecutive equal synchronized samples required before the filtered ps2_clk level changes.
REQ-002 SHALL provide parameter TIMEOUT, default 100000, the maximum number of clk cycles allowed between falling edges inside a frame.
REQ-003 SHALL have port clk, input, 1, system clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port ps2_clk, input, 1, asynchronous PS/2 clock line.
REQ-006 SHALL have port ps2_data, input, 1, asynchronous PS/2 data line.
REQ-007 SHALL have port key_code, output, 8, scancode of the key currently held, or 8'h00 when no key is held; feeds keyboard_data of the game logic.
REQ-008 SHALL have port key_ready, output, 1, one-cycle pulse on every accepted make code, including typematic repeats.
REQ-009 SHALL have port key_held, output, 1, level that is high from a make code until the matching break code.
REQ-010 SHALL have port key_ext, output, 1, set when the held key's make code was preceded by 8'hE0.
REQ-011 SHALL have port frame_err, output, 1, one-cycle pulse on each discarded frame.

Function
REQ-012 SHALL synchronize ps2_clk and ps2_data through two flops each, with reset value 1.
REQ-013 SHALL change the filtered clock only after FILTER_LEN consecutive identical synchronized samples; shorter glitches are ignored.
REQ-014 SHALL detect the filtered-clock 1->0 transition and sample the synchronized ps2_data in that same cycle.
REQ-015 SHALL implement the receiver FSM with states IDLE, DATA, PARITY and STOP, advancing only on sampling edges.
REQ-016 In IDLE, SHALL go to DATA on sampled 0 (start bit) and stay in IDLE on sampled 1, with no error.
REQ-017 In DATA, SHALL shift 8 bits LSB first using a 3-bit counter, then go to PARITY after bit 7.
REQ-018 In PARITY, SHALL capture the parity bit and go to STOP.
REQ-019 In STOP, SHALL accept the frame when stop=1 and the XOR of the 8 data bits plus parity is 1 (odd parity).
REQ-020 In STOP, SHALL otherwise discard the frame, pulse frame_err, and clear the break and extended flags.
REQ-021 SHALL always return to IDLE after STOP.
REQ-022 SHALL count cycles since the last sampling edge while not in IDLE.
REQ-023 When that count reaches TIMEOUT, SHALL discard the partial frame, return to IDLE, pulse frame_err and clear both flags.
REQ-024 SHALL treat an accepted byte 8'hF0 as setting the break flag, with no output change.
REQ-025 SHALL treat an accepted byte 8'hE0 as setting the extended flag, with no output change.
REQ-026 On any other accepted byte with break flag=0, SHALL load the byte into key_code and the extended flag into key_ext, set key_held=1, and pulse key_ready.
REQ-027 On any other accepted byte with break flag=1 and byte equal to key_code, SHALL set key_code=8'h00, key_held=0 and key_ext=0.
REQ-028 On any other accepted byte with break flag=1 and byte not equal to key_code, SHALL ignore the byte.
REQ-029 SHALL clear both flags after every non-prefix accepted byte.
REQ-030 SHALL update outputs and flags exactly 1 clk after the cycle in which the stop-bit edge is detected (key_ready high in that cycle only).
REQ-031 SHALL accept a new make code while a key is held: key_code is replaced and key_ready pulses.
REQ-032 SHALL never assert key_ready and frame_err in the same cycle.

Reset
REQ-033 While rst=1, SHALL force the FSM to IDLE, the counters and shift register to 0, both flags to 0, and the sync flops and filtered clock to 1.
REQ-034 While rst=1, SHALL hold key_code=8'h00 and key_held, key_ext, key_ready and frame_err at 0.
REQ-035 SHALL abandon any frame in progress on reset without pulsing frame_err.
REQ-036 SHALL begin decoding of a new start bit on the first sampling edge after rst falls.

Verification
REQ-037 Frame 0x1C (parity 0, stop 1) -> exactly one key_ready pulse, key_code=0x1C, key_held=1, key_ext=0.
REQ-038 Then frames F0,1C -> no key_ready, key_code=0x00, key_held=0; a subsequent F0,23 changes nothing.
REQ-039 Frames E0,75 -> key_ready pulse, key_code=0x75, key_ext=1; then E0,F0,75 -> key_code=0x00, key_ext=0.
REQ-040 Frame 0x23 with parity bit 1 -> frame_err single pulse, key_code unchanged; ps2_clk glitch of FILTER_LEN-1 cycles -> no bit sampled.
REQ-041 Stop after 4 data bits and idle TIMEOUT cycles -> frame_err pulse, FSM in IDLE; next frame 0x1D -> key_code=0x1D.
REQ-042 rst pulsed after 5 data bits -> all outputs 0, no frame_err; next frame 0x1C decoded correctly.
